// File: rtl/vid_timing_pkg.sv
// Shared timing defaults and the scheduler state type for the video frame scheduler.
package vid_timing_pkg;

   localparam int DEF_H_SYNC  = 40;
   localparam int DEF_H_BACK  = 220;
   localparam int DEF_H_DISP  = 1280;
   localparam int DEF_H_FRONT = 110;
   localparam int DEF_V_SYNC  = 5;
   localparam int DEF_V_BACK  = 20;
   localparam int DEF_V_DISP  = 720;
   localparam int DEF_V_FRONT = 5;
   localparam int DEF_ADDR_W  = 20;
   localparam int PIX_W       = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Raster h/v counters with sync/active decode and end-of-frame flag.
module vid_timing_cnt
   import vid_timing_pkg::*;
#(
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BACK  = DEF_H_BACK,
   parameter int H_DISP  = DEF_H_DISP,
   parameter int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BACK  = DEF_V_BACK,
   parameter int V_DISP  = DEF_V_DISP,
   parameter int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic vs,
   output logic hs,
   output logic act,
   output logic frame_end
);

   localparam int HW = cnt_w(H_TOTAL);
   localparam int VW = cnt_w(V_TOTAL);

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC + H_BACK + H_DISP - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_SYNC + V_BACK + V_DISP - 1);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_last_s, v_last_s;

   assign h_last_s = (h_q == H_LAST);
   assign v_last_s = (v_q == V_LAST);

   // Next raster position; counters sit at 0/0 whenever the scheduler is idle.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!run) begin
         h_d = '0;
         v_d = '0;
      end else if (h_last_s) begin
         h_d = '0;
         if (v_last_s) begin
            v_d = '0;
         end else begin
            v_d = v_q + VW'(1);
         end
      end else begin
         h_d = h_q + HW'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign vs        = run & (v_q < V_SYNC_END);
   assign hs        = run & (h_q < H_SYNC_END);
   assign act       = run & (h_q >= H_ACT_FIRST) & (h_q <= H_ACT_LAST)
                          & (v_q >= V_ACT_FIRST) & (v_q <= V_ACT_LAST);
   assign frame_end = run & h_last_s & v_last_s;

endmodule

// File: rtl/vid_frame_sched.sv
// Frame scheduler: run/idle control, frame-buffer read addressing and a two-stage
// pipe that realigns sync/valid with the 1-cycle-latency RAM data.
module vid_frame_sched
   import vid_timing_pkg::*;
#(
   parameter  int H_SYNC  = DEF_H_SYNC,
   parameter  int H_BACK  = DEF_H_BACK,
   parameter  int H_DISP  = DEF_H_DISP,
   parameter  int H_FRONT = DEF_H_FRONT,
   parameter  int V_SYNC  = DEF_V_SYNC,
   parameter  int V_BACK  = DEF_V_BACK,
   parameter  int V_DISP  = DEF_V_DISP,
   parameter  int V_FRONT = DEF_V_FRONT,
   parameter  int ADDR_W  = DEF_ADDR_W,
   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT,
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cont_mode,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              out_vsync,
   output logic              out_hsync,
   output logic              out_valid,
   output logic [PIX_W-1:0]  out_data
);

   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(H_DISP * V_DISP - 1);

   sched_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              run_s, vs_s, hs_s, act_s, frame_end_s, rd_en_s;

   logic              vs_d1_q, vs_d1_d, hs_d1_q, hs_d1_d;
   logic              act_d1_q, act_d1_d, eof_d1_q, eof_d1_d;
   logic              out_vsync_q, out_vsync_d, out_hsync_q, out_hsync_d;
   logic              out_valid_q, out_valid_d, frame_done_q, frame_done_d;
   logic [PIX_W-1:0]  out_data_q, out_data_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   assign run_s   = (state_q == RUN);
   assign rd_en_s = act_s & run_s;

   vid_timing_cnt #(
      .H_SYNC  (H_SYNC),
      .H_BACK  (H_BACK),
      .H_DISP  (H_DISP),
      .H_TOTAL (H_TOTAL),
      .V_SYNC  (V_SYNC),
      .V_BACK  (V_BACK),
      .V_DISP  (V_DISP),
      .V_TOTAL (V_TOTAL)
   ) u_timing_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run_s),
      .vs        (vs_s),
      .hs        (hs_s),
      .act       (act_s),
      .frame_end (frame_end_s)
   );

   // Run/idle control and pixel address; the address rewinds at every frame boundary.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               addr_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (frame_end_s) begin
               state_d = cont_mode ? RUN : IDLE;
               addr_d  = '0;
            end else if (rd_en_s) begin
               addr_d = (addr_q == PIX_LAST) ? '0 : addr_q + ADDR_W'(1);
            end else begin
               addr_d = addr_q;
            end
         end
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // Alignment pipe: stage 1 waits for RAM data, stage 2 drives the outputs.
   always_comb begin
      vs_d1_d      = vs_s;
      hs_d1_d      = hs_s;
      act_d1_d     = act_s;
      eof_d1_d     = frame_end_s;
      out_vsync_d  = vs_d1_q;
      out_hsync_d  = hs_d1_q;
      out_valid_d  = act_d1_q;
      out_data_d   = act_d1_q ? rd_data : 8'd0;
      frame_done_d = eof_d1_q;
      frame_cnt_d  = eof_d1_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   // All scheduler state; reset aborts any frame in flight and clears the pipe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         vs_d1_q      <= 1'b0;
         hs_d1_q      <= 1'b0;
         act_d1_q     <= 1'b0;
         eof_d1_q     <= 1'b0;
         out_vsync_q  <= 1'b0;
         out_hsync_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'd0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         vs_d1_q      <= vs_d1_d;
         hs_d1_q      <= hs_d1_d;
         act_d1_q     <= act_d1_d;
         eof_d1_q     <= eof_d1_d;
         out_vsync_q  <= out_vsync_d;
         out_hsync_q  <= out_hsync_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign busy       = run_s;
   assign rd_en      = rd_en_s;
   assign rd_addr    = addr_q;
   assign out_vsync  = out_vsync_q;
   assign out_hsync  = out_hsync_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vid_frame_sched.sv
// Scoreboard bench for vid_frame_sched on a 10x6 raster (4x3 active pixels).
module tb_vid_frame_sched;

   localparam int HS = 2, HB = 2, HD = 4, HF = 2, HT = 10;
   localparam int VS = 1, VB = 1, VD = 3, VF = 1, VT = 6;
   localparam int AW = 8;
   localparam int BIG = 1000000;

   logic          clk = 1'b0;
   logic          rst_n, start, cont_mode;
   logic          busy, frame_done, rd_en;
   logic [15:0]   frame_cnt;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          out_vsync, out_hsync, out_valid;
   logic [7:0]    out_data;

   vid_frame_sched #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont_mode(cont_mode),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_vsync(out_vsync), .out_hsync(out_hsync),
      .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame-buffer model: mem[a] = a[7:0], registered read; junk when not reading.
   always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'hEE;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct { int cyc; int val; } ev_t;
   ev_t q_rd[$], q_beat[$], q_done[$], q_vs[$], q_hs[$];

   function automatic ev_t mk(input int c, input int v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      return e;
   endfunction

   // Expected events for a frame whose first counter cycle is s; only events
   // at or before cycle 'last' are queued. For this raster the first beat is s+26,
   // the last rd_en s+47 (addr 11) and frame_done s+61.
   task automatic push_frame(input int s, input int cnt, input int last);
      for (int v = 0; v < VT; v++) begin
         for (int h = 0; h < HT; h++) begin
            int p = v * HT + h;
            if (h == 0 && v == 0 && s + p + 2 <= last) q_vs.push_back(mk(s + p + 2, 0));
            if (h == 0 && s + p + 2 <= last) q_hs.push_back(mk(s + p + 2, 0));
            if (v >= VS + VB && v < VS + VB + VD && h >= HS + HB && h < HS + HB + HD) begin
               int a = (v - VS - VB) * HD + (h - HS - HB);
               if (s + p <= last) q_rd.push_back(mk(s + p, a));
               if (s + p + 2 <= last) q_beat.push_back(mk(s + p + 2, a));
            end
         end
      end
      if (s + HT * VT + 1 <= last) q_done.push_back(mk(s + HT * VT + 1, cnt));
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_out_vsync"}, out_vsync, 0);
      chk({tag, "_out_hsync"}, out_hsync, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   logic prev_vs = 1'b0, prev_hs = 1'b0;
   int   vs_len = 0, hs_len = 0;
   always @(negedge clk) begin
      ev_t e;
      if (cyc >= 2) begin
         if (rd_en === 1'b1) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else begin e = q_rd.pop_front(); chk("rd_cycle", cyc, e.cyc); chk("rd_addr", rd_addr, e.val); end
         end
         if (out_valid === 1'b1) begin
            if (q_beat.size() == 0) chk("beat_unexpected", 1, 0);
            else begin e = q_beat.pop_front(); chk("beat_cycle", cyc, e.cyc); chk("out_data", out_data, e.val); end
         end else begin
            chk("data_blank", out_data, 0);
         end
         chk("valid_in_sync", out_valid & (out_hsync | out_vsync), 0);
         if (frame_done === 1'b1) begin
            if (q_done.size() == 0) chk("done_unexpected", 1, 0);
            else begin e = q_done.pop_front(); chk("done_cycle", cyc, e.cyc); chk("frame_cnt", frame_cnt, e.val); end
         end
         if (out_vsync === 1'b1 && !prev_vs) begin
            if (q_vs.size() == 0) chk("vs_unexpected", 1, 0);
            else begin e = q_vs.pop_front(); chk("vs_rise_cycle", cyc, e.cyc); end
         end
         if (out_hsync === 1'b1 && !prev_hs) begin
            if (q_hs.size() == 0) chk("hs_unexpected", 1, 0);
            else begin e = q_hs.pop_front(); chk("hs_rise_cycle", cyc, e.cyc); end
         end
         if (out_vsync === 1'b1) vs_len = vs_len + 1;
         else begin
            if (prev_vs) chk("vsync_width", vs_len, VS * HT);
            vs_len = 0;
         end
         if (out_hsync === 1'b1) hs_len = hs_len + 1;
         else begin
            if (prev_hs) chk("hsync_width", hs_len, HS);
            hs_len = 0;
         end
         prev_vs = (out_vsync === 1'b1);
         prev_hs = (out_hsync === 1'b1);
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation ran past its time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cont_mode = 1'b0;
      goto(2);
      chk_all_zero("reset");
      goto(3);
      rst_n = 1'b1;

      // Single-shot frame; a start on its final counter cycle must be ignored.
      goto(5);
      push_frame(6, 1, BIG);
      start = 1'b1;
      goto(6);
      start = 1'b0;
      chk("t1_busy_run", busy, 1);
      chk("t1_first_addr", rd_addr, 0);
      goto(65);
      start = 1'b1;
      goto(66);
      start = 1'b0;
      chk("t1_busy_end", busy, 0);
      goto(67);
      chk("t1_busy_at_done", busy, 0);
      chk("t1_cnt_at_done", frame_cnt, 1);
      goto(68);
      chk("t1_no_restart", busy, 0);

      // Start pulsed mid-frame: no restart, one frame_done.
      goto(70);
      push_frame(71, 2, BIG);
      start = 1'b1;
      goto(71);
      start = 1'b0;
      goto(101);
      start = 1'b1;
      goto(102);
      start = 1'b0;
      chk("t4_busy", busy, 1);

      // Continuous mode, three back-to-back frames; cont_mode dropped mid third frame.
      goto(135);
      push_frame(136, 3, BIG);
      push_frame(196, 4, BIG);
      push_frame(256, 5, BIG);
      cont_mode = 1'b1;
      start = 1'b1;
      goto(136);
      start = 1'b0;
      goto(196);
      chk("t3_busy_f2", busy, 1);
      goto(256);
      chk("t3_busy_f3", busy, 1);
      goto(286);
      cont_mode = 1'b0;
      goto(316);
      chk("t3_busy_end", busy, 0);

      // Single-shot with cont_mode raised mid-frame: a second frame follows.
      goto(320);
      push_frame(321, 6, BIG);
      push_frame(381, 7, BIG);
      start = 1'b1;
      goto(321);
      start = 1'b0;
      goto(351);
      cont_mode = 1'b1;
      goto(381);
      chk("t6_busy_f2", busy, 1);
      goto(411);
      cont_mode = 1'b0;
      goto(441);
      chk("t6_busy_end", busy, 0);

      // Reset on line 3 aborts the frame; a fresh start runs cleanly from address 0.
      goto(445);
      push_frame(446, 8, 481);
      start = 1'b1;
      goto(446);
      start = 1'b0;
      goto(481);
      rst_n = 1'b0;
      goto(482);
      rst_n = 1'b1;
      chk_all_zero("abort");
      goto(484);
      push_frame(485, 1, BIG);
      start = 1'b1;
      goto(485);
      start = 1'b0;
      chk("t5_restart_addr", rd_addr, 0);
      chk("t5_restart_busy", busy, 1);

      goto(550);
      chk("left_rd", q_rd.size(), 0);
      chk("left_beat", q_beat.size(), 0);
      chk("left_done", q_done.size(), 0);
      chk("left_vs", q_vs.size(), 0);
      chk("left_hs", q_hs.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
